// File: rtl/time_set_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : time_set_ctrl_pkg
// Brief  : Mode encoding shared by the clock setting controller, blinker and
//          time counters.
// Rev    : 1.0  initial release
// ============================================================================
package time_set_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2
    } mode_t;

    // Successor of a mode on a MODE key press.
    function automatic mode_t next_mode(input mode_t m);
        mode_t r;
        case (m)
            MODE_RUN:    r = MODE_SET_HR;
            MODE_SET_HR: r = MODE_SET_MIN;
            default:     r = MODE_RUN;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/time_set_ctrl_key_edge.sv
`default_nettype none
// ============================================================================
// Module : key_edge
// Brief  : Rising-edge detector on a debounced key level; history resets to 1
//          so a key held through reset produces no edge.
// Rev    : 1.0  initial release
// ============================================================================
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic level_in,
    output logic rise_out
);

    logic r_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= 1'b1;
        end else begin
            r_hist <= level_in;
        end
    end

    // Combinational so the registered consumer answers in the next cycle.
    assign rise_out = level_in & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module : time_set_ctrl
// Brief  : Clock setting-mode sequencer with hour/minute increment strobes,
//          press-and-hold auto-repeat and idle timeout back to RUN.
// Rev    : 1.0  initial release
// ============================================================================
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W          = 29,
    parameter int unsigned HOLD_CYCLES    = 50_000_000,
    parameter int unsigned REPEAT_CYCLES  = 10_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode_in,
    input  logic       key_inc_in,
    output logic [1:0] mode,
    output logic       run_en,
    output logic       inc_hr,
    output logic       inc_min,
    output logic       sec_clr
);

    localparam logic [CNT_W-1:0] c_HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_REPEAT_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic w_mode_rise;
    logic w_inc_rise;

    key_edge u_mode_edge (
        .clk      (clk),
        .rst      (rst),
        .level_in (key_mode_in),
        .rise_out (w_mode_rise)
    );

    key_edge u_inc_edge (
        .clk      (clk),
        .rst      (rst),
        .level_in (key_inc_in),
        .rise_out (w_inc_rise)
    );

    mode_t            r_mode,    w_nxt_mode;
    logic [CNT_W-1:0] r_hold,    w_nxt_hold;
    logic [CNT_W-1:0] r_to,      w_nxt_to;
    logic             r_armed,   w_nxt_armed;   // INC press accepted and still held
    logic             r_rep,     w_nxt_rep;     // first repeat already issued
    logic             r_inc_hr,  w_nxt_inc_hr;
    logic             r_inc_min, w_nxt_inc_min;
    logic             r_sec_clr, w_nxt_sec_clr;
    logic             w_strobe;
    logic             w_repeat_due;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode    <= MODE_RUN;
            r_hold    <= '0;
            r_to      <= '0;
            r_armed   <= 1'b0;
            r_rep     <= 1'b0;
            r_inc_hr  <= 1'b0;
            r_inc_min <= 1'b0;
            r_sec_clr <= 1'b0;
        end else begin
            r_mode    <= w_nxt_mode;
            r_hold    <= w_nxt_hold;
            r_to      <= w_nxt_to;
            r_armed   <= w_nxt_armed;
            r_rep     <= w_nxt_rep;
            r_inc_hr  <= w_nxt_inc_hr;
            r_inc_min <= w_nxt_inc_min;
            r_sec_clr <= w_nxt_sec_clr;
        end
    end

    always_comb begin
        w_nxt_mode    = r_mode;
        w_nxt_hold    = r_hold;
        w_nxt_to      = r_to;
        w_nxt_armed   = r_armed;
        w_nxt_rep     = r_rep;
        w_nxt_sec_clr = 1'b0;
        w_strobe      = 1'b0;
        w_repeat_due  = r_armed & key_inc_in &
                        (r_rep ? (r_hold == c_REPEAT_LAST) : (r_hold == c_HOLD_LAST));

        if (r_mode == MODE_RUN) begin
            w_nxt_hold  = '0;
            w_nxt_to    = '0;
            w_nxt_armed = 1'b0;
            w_nxt_rep   = 1'b0;
            if (w_mode_rise) begin
                w_nxt_mode = MODE_SET_HR;
            end
        end else if (w_mode_rise) begin
            // MODE has priority over INC and timeout; a held INC must be re-pressed.
            w_nxt_mode    = next_mode(r_mode);
            w_nxt_sec_clr = (r_mode == MODE_SET_MIN);
            w_nxt_hold    = '0;
            w_nxt_to      = '0;
            w_nxt_armed   = 1'b0;
            w_nxt_rep     = 1'b0;
        end else if (w_inc_rise) begin
            w_strobe    = 1'b1;
            w_nxt_hold  = '0;
            w_nxt_to    = '0;
            w_nxt_armed = 1'b1;
            w_nxt_rep   = 1'b0;
        end else if (w_repeat_due) begin
            w_strobe   = 1'b1;
            w_nxt_hold = '0;
            w_nxt_to   = '0;
            w_nxt_rep  = 1'b1;
        end else if (r_to == c_TIMEOUT_LAST) begin
            w_nxt_mode  = MODE_RUN;
            w_nxt_hold  = '0;
            w_nxt_to    = '0;
            w_nxt_armed = 1'b0;
            w_nxt_rep   = 1'b0;
        end else begin
            w_nxt_to = r_to + CNT_W'(1);
            if (r_armed && key_inc_in) begin
                w_nxt_hold = r_hold + CNT_W'(1);
            end else begin
                w_nxt_hold  = '0;
                w_nxt_armed = 1'b0;
                w_nxt_rep   = 1'b0;
            end
        end

        w_nxt_inc_hr  = w_strobe & (r_mode == MODE_SET_HR);
        w_nxt_inc_min = w_strobe & (r_mode == MODE_SET_MIN);
    end

    assign mode    = r_mode;
    assign run_en  = (r_mode == MODE_RUN);
    assign inc_hr  = r_inc_hr;
    assign inc_min = r_inc_min;
    assign sec_clr = r_sec_clr;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_time_set_ctrl
// Brief  : Directed and randomized bench for time_set_ctrl against a
//          cycle-indexed behavioural model of the setting rules.
// Rev    : 1.0  initial release
// ============================================================================
module tb_time_set_ctrl;

    localparam int CNT_W = 8;
    localparam int H     = 20;
    localparam int R     = 5;
    localparam int T     = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_mode_in;
    logic       key_inc_in;
    logic [1:0] mode;
    logic       run_en;
    logic       inc_hr;
    logic       inc_min;
    logic       sec_clr;

    time_set_ctrl #(
        .CNT_W          (CNT_W),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_mode_in (key_mode_in),
        .key_inc_in  (key_inc_in),
        .mode        (mode),
        .run_en      (run_en),
        .inc_hr      (inc_hr),
        .inc_min     (inc_min),
        .sec_clr     (sec_clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: mode number, cycle of the accepted press and of the last activity.
    int cyc     = 0;
    int m_mode  = 0;
    bit m_armed = 1'b0;
    bit m_pm    = 1'b1;
    bit m_pi    = 1'b1;
    int m_press = 0;
    int m_last  = 0;
    bit e_hr, e_min, e_clr;
    int hr_cnt, min_cnt;

    function automatic bit repeat_due(input int k);
        return (k == H) || (k > H && ((k - H) % R) == 0);
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_armed = 1'b0;
        m_pm    = 1'b1;
        m_pi    = 1'b1;
        e_hr    = 1'b0;
        e_min   = 1'b0;
        e_clr   = 1'b0;
    endtask

    task automatic model_step();
        bit mr, ir, strobe;
        mr     = key_mode_in & ~m_pm;
        ir     = key_inc_in & ~m_pi;
        strobe = 1'b0;
        e_clr  = 1'b0;
        if (m_mode == 0) begin
            m_armed = 1'b0;
            if (mr) begin
                m_mode = 1;
                m_last = cyc;
            end
        end else if (mr) begin
            e_clr   = (m_mode == 2);
            m_mode  = (m_mode == 1) ? 2 : 0;
            m_armed = 1'b0;
            m_last  = cyc;
        end else if (ir) begin
            strobe  = 1'b1;
            m_armed = 1'b1;
            m_press = cyc;
            m_last  = cyc;
        end else begin
            if (m_armed && !key_inc_in) m_armed = 1'b0;
            if (m_armed && repeat_due(cyc - m_press)) begin
                strobe = 1'b1;
                m_last = cyc;
            end else if (cyc - m_last == T) begin
                m_mode  = 0;
                m_armed = 1'b0;
            end
        end
        // Strobe targets the mode that was active when it was issued.
        e_hr  = strobe && (m_mode == 1);
        e_min = strobe && (m_mode == 2);
        m_pm  = key_mode_in;
        m_pi  = key_inc_in;
    endtask

    task automatic check_outputs(input string tag);
        logic [5:0] obs, exp;
        obs = {mode, run_en, inc_hr, inc_min, sec_clr};
        exp = {2'(m_mode), (m_mode == 0), e_hr, e_min, e_clr};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b (mode,run_en,hr,min,clr)",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        cyc++;
        model_step();
        check_outputs(tag);
        if (inc_hr)  hr_cnt++;
        if (inc_min) min_cnt++;
    endtask

    task automatic press_mode(input int hold, input int gap, input string tag);
        key_mode_in = 1'b1;
        repeat (hold) tick(tag);
        key_mode_in = 1'b0;
        repeat (gap) tick(tag);
    endtask

    initial begin
        int t0;
        int bound;

        // Reset with INC held: no edge on release.
        rst         = 1'b1;
        key_mode_in = 1'b0;
        key_inc_in  = 1'b1;
        model_reset();
        #12;
        check_outputs("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) tick("inc_held_at_reset");
        key_inc_in = 1'b0;
        repeat (3) tick("inc_release_run");
        key_inc_in = 1'b1;
        repeat (3) tick("inc_in_run");
        key_inc_in = 1'b0;
        tick("inc_in_run");

        // Three MODE presses cycle the modes; sec_clr on return to RUN.
        press_mode(3, 3, "mode_cycle");
        press_mode(3, 3, "mode_cycle");
        press_mode(3, 3, "mode_cycle");
        check_int("mode_cycle_end", int'(mode), 0);

        // SET_HR hold-to-repeat.
        press_mode(2, 2, "enter_set_hr");
        hr_cnt     = 0;
        min_cnt    = 0;
        key_inc_in = 1'b1;
        repeat (41) tick("hold_repeat");
        key_inc_in = 1'b0;
        repeat (8) tick("hold_release");
        check_int("hold_hr_strobes", hr_cnt, 6);
        check_int("hold_min_strobes", min_cnt, 0);

        // SET_MIN, MODE and INC edges together: MODE wins.
        press_mode(2, 2, "enter_set_min");
        min_cnt     = 0;
        key_mode_in = 1'b1;
        key_inc_in  = 1'b1;
        tick("simul_edge");
        check_int("simul_mode", int'(mode), 0);
        check_int("simul_sec_clr", int'(sec_clr), 1);
        repeat (3) tick("simul_hold");
        key_mode_in = 1'b0;
        key_inc_in  = 1'b0;
        repeat (3) tick("simul_release");
        check_int("simul_min_strobes", min_cnt, 0);

        // Idle timeout in SET_HR.
        key_mode_in = 1'b1;
        tick("timeout_enter");
        t0          = cyc;
        key_mode_in = 1'b0;
        bound       = 0;
        while (mode != 2'd0 && bound < 200) begin
            tick("timeout_wait");
            bound++;
        end
        check_int("timeout_latency", cyc - t0, T);
        repeat (3) tick("after_timeout");

        // Async reset mid-repeat in SET_MIN.
        press_mode(1, 2, "to_set_hr");
        press_mode(1, 2, "to_set_min");
        key_inc_in = 1'b1;
        repeat (28) tick("set_min_repeat");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        #2;
        rst = 1'b0;
        repeat (20) tick("after_rst_held");
        key_inc_in = 1'b0;
        repeat (3) tick("after_rst_release");

        // Randomized key levels.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3)  key_mode_in = ~key_mode_in;
            if ($urandom_range(0, 99) < 6)  key_inc_in  = ~key_inc_in;
            tick("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
